// File: rtl/pipe_ctrl_unit.sv
// Pipeline hazard/control unit: stalls, flushes, next-PC select,
// multicycle-op wait, and exception/interrupt entry and return.
module pipe_ctrl_unit #(
    parameter int STAGES   = 5,
    parameter int BR_STAGE = 2,
    parameter int MC_LAT   = 4,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              load_use,
    input  logic              jump_taken,
    input  logic              jr_taken,
    input  logic              branch_taken,
    input  logic              mc_start,
    input  logic              exception_req,
    input  logic              eret,
    input  logic              irq,
    input  logic              irq_enable,
    input  logic [DATA_W-1:0] id_pc,
    output logic [STAGES-1:0] stall,
    output logic [STAGES-1:0] flush,
    output logic [2:0]        pc_sel,
    output logic [DATA_W-1:0] epc,
    output logic              in_handler,
    output logic              irq_ack,
    output logic              mc_busy
);

    localparam int CW = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;

    typedef enum logic [1:0] {RUN, MC_WAIT, TRAP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          irq_pending;

    logic run, blocked;
    logic exc_trap, irq_trap, trap;
    logic br_go, eret_go, jr_go, jump_go, mc_go, lu_go;

    assign run      = (state == RUN);
    assign blocked  = branch_taken | jump_taken | jr_taken | eret | load_use;
    assign exc_trap = run & exception_req;
    assign irq_trap = run & ~exception_req & irq_pending & ~blocked;
    assign trap     = exc_trap | irq_trap;
    assign br_go    = run & ~trap & branch_taken;
    assign eret_go  = run & ~trap & ~branch_taken & eret;
    assign jr_go    = run & ~trap & ~branch_taken & ~eret & jr_taken;
    assign jump_go  = run & ~trap & ~branch_taken & ~eret & ~jr_taken
                    & jump_taken;
    assign mc_go    = run & ~trap & ~branch_taken & ~eret & ~jr_taken
                    & ~jump_taken & mc_start;
    assign lu_go    = run & ~trap & ~branch_taken & ~eret & ~jr_taken
                    & ~jump_taken & ~mc_start & load_use;

    always_comb begin
        stall  = '0;
        flush  = '0;
        pc_sel = 3'd0;
        if (state == MC_WAIT || mc_go) begin
            for (int i = 0; i <= BR_STAGE; i++) stall[i] = 1'b1;
            flush[BR_STAGE] = 1'b1;
        end else if (trap) begin
            flush[0] = 1'b1;
            flush[1] = 1'b1;
            pc_sel   = exc_trap ? 3'd4 : 3'd5;
        end else if (br_go) begin
            for (int i = 0; i < BR_STAGE; i++) flush[i] = 1'b1;
            pc_sel = 3'd1;
        end else if (eret_go) begin
            flush[0] = 1'b1;
            pc_sel   = 3'd6;
        end else if (jr_go) begin
            flush[0] = 1'b1;
            pc_sel   = 3'd3;
        end else if (jump_go) begin
            flush[0] = 1'b1;
            pc_sel   = 3'd2;
        end else if (lu_go) begin
            stall[0]          = 1'b1;
            stall[1]          = 1'b1;
            flush[BR_STAGE-1] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state       <= RUN;
            cnt         <= '0;
            epc         <= '0;
            in_handler  <= 1'b0;
            irq_pending <= 1'b0;
            irq_ack     <= 1'b0;
            mc_busy     <= 1'b0;
        end else begin
            irq_ack <= irq_trap;
            if (irq_trap)
                irq_pending <= 1'b0;
            else if (irq & irq_enable & ~in_handler)
                irq_pending <= 1'b1;
            case (state)
                RUN: begin
                    if (trap) begin
                        state      <= TRAP;
                        in_handler <= 1'b1;
                        if (!in_handler) epc <= id_pc;
                    end else if (eret_go) begin
                        in_handler <= 1'b0;
                    end else if (mc_go) begin
                        cnt <= CW'(MC_LAT - 1);
                        // a one-cycle op completes in its own start cycle
                        if (MC_LAT > 1) begin
                            state   <= MC_WAIT;
                            mc_busy <= 1'b1;
                        end
                    end
                end
                MC_WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state   <= RUN;
                        mc_busy <= 1'b0;
                    end
                end
                TRAP:    state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit with default parameters.
module tb_pipe_ctrl_unit;

    logic        clk = 1'b0;
    logic        reset_b;
    logic        load_use, jump_taken, jr_taken, branch_taken;
    logic        mc_start, exception_req, eret, irq, irq_enable;
    logic [31:0] id_pc;
    logic [4:0]  stall, flush;
    logic [2:0]  pc_sel;
    logic [31:0] epc;
    logic        in_handler, irq_ack, mc_busy;

    int checks = 0;
    int errors = 0;

    pipe_ctrl_unit dut (
        .clk(clk), .reset_b(reset_b),
        .load_use(load_use), .jump_taken(jump_taken),
        .jr_taken(jr_taken), .branch_taken(branch_taken),
        .mc_start(mc_start), .exception_req(exception_req),
        .eret(eret), .irq(irq), .irq_enable(irq_enable),
        .id_pc(id_pc), .stall(stall), .flush(flush),
        .pc_sel(pc_sel), .epc(epc), .in_handler(in_handler),
        .irq_ack(irq_ack), .mc_busy(mc_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        load_use = 0; jump_taken = 0; jr_taken = 0; branch_taken = 0;
        mc_start = 0; exception_req = 0; eret = 0; irq = 0;
        irq_enable = 0; id_pc = '0;
    endtask

    initial begin
        clr();
        reset_b = 0;
        tick(); tick();
        check("rst_busy", 32'(mc_busy), 0);
        check("rst_epc", epc, 0);
        check("rst_inh", 32'(in_handler), 0);
        check("rst_ack", 32'(irq_ack), 0);
        reset_b = 1;
        tick();
        #2;
        check("idle_stall", 32'(stall), 0);
        check("idle_flush", 32'(flush), 0);
        check("idle_pcsel", 32'(pc_sel), 0);

        // load-use bubble
        tick(); load_use = 1; #2;
        check("lu_stall", 32'(stall), 32'h03);
        check("lu_flush", 32'(flush), 32'h02);
        check("lu_pcsel", 32'(pc_sel), 0);
        tick(); clr(); #2;
        check("lu_after", 32'(stall), 0);

        // branch beats jump and mc_start
        tick(); branch_taken = 1; jump_taken = 1; mc_start = 1; #2;
        check("br_flush", 32'(flush), 32'h03);
        check("br_pcsel", 32'(pc_sel), 1);
        check("br_stall", 32'(stall), 0);
        tick(); clr(); #2;
        check("br_busy", 32'(mc_busy), 0);

        // jr beats jump
        tick(); jr_taken = 1; jump_taken = 1; #2;
        check("jr_pcsel", 32'(pc_sel), 3);
        check("jr_flush", 32'(flush), 32'h01);
        tick(); clr(); jump_taken = 1; #2;
        check("j_pcsel", 32'(pc_sel), 2);

        // multicycle op, 4 stall cycles, jump ignored meanwhile
        tick(); clr(); mc_start = 1; #2;
        check("mc0_stall", 32'(stall), 32'h07);
        check("mc0_flush", 32'(flush), 32'h04);
        check("mc0_busy", 32'(mc_busy), 0);
        for (int k = 0; k < 3; k++) begin
            tick(); clr(); jump_taken = 1; #2;
            check("mcw_stall", 32'(stall), 32'h07);
            check("mcw_flush", 32'(flush), 32'h04);
            check("mcw_pcsel", 32'(pc_sel), 0);
            check("mcw_busy", 32'(mc_busy), 1);
        end
        tick(); clr(); #2;
        check("mc_end_stall", 32'(stall), 0);
        check("mc_end_busy", 32'(mc_busy), 0);

        // irq deferred behind a branch
        tick(); irq = 1; irq_enable = 1; id_pc = 32'h00400010;
        branch_taken = 1; #2;
        check("irqd_pcsel", 32'(pc_sel), 1);
        tick(); branch_taken = 0; irq = 0; #2;
        check("irq_pcsel", 32'(pc_sel), 5);
        check("irq_flush", 32'(flush), 32'h03);
        tick(); clr(); #2;
        check("irq_ack1", 32'(irq_ack), 1);
        check("irq_epc", epc, 32'h00400010);
        check("irq_inh", 32'(in_handler), 1);
        check("trap_stall", 32'(stall), 0);
        check("trap_flush", 32'(flush), 0);
        tick(); #2;
        check("irq_ack0", 32'(irq_ack), 0);

        // nested exception keeps epc, then return
        tick(); exception_req = 1; id_pc = 32'h80000020; #2;
        check("exc_pcsel", 32'(pc_sel), 4);
        tick(); clr(); #2;
        check("exc_epc", epc, 32'h00400010);
        check("exc_inh", 32'(in_handler), 1);
        tick(); eret = 1; #2;
        check("eret_pcsel", 32'(pc_sel), 6);
        check("eret_flush", 32'(flush), 32'h01);
        tick(); clr(); #2;
        check("eret_inh", 32'(in_handler), 0);

        // reset aborts MC_WAIT asynchronously
        tick(); mc_start = 1;
        tick(); clr(); #2;
        check("rmc_busy", 32'(mc_busy), 1);
        #1 reset_b = 0;
        #1;
        check("rmc_busy0", 32'(mc_busy), 0);
        check("rmc_stall", 32'(stall), 0);
        check("rmc_epc", epc, 0);
        tick(); tick();
        reset_b = 1;
        tick(); #2;
        check("post_stall", 32'(stall), 0);
        check("post_flush", 32'(flush), 0);
        check("post_pcsel", 32'(pc_sel), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
